// File: rtl/mmss_counter.sv
// Stopwatch time-keeping core: minutes/seconds counter advanced by tick pulses,
// with pause toggle and per-field adjust stepping.
module mmss_counter #(
    parameter int unsigned SEC_MAX = 59,
    parameter int unsigned MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       btnR,
    input  logic       tick_norm,
    input  logic       tick_adj,
    input  logic       btnP,
    input  logic       swADJ,
    input  logic       swSEL,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       paused,
    output logic       wrap
);

    localparam logic [5:0] C_SEC_MAX = 6'(SEC_MAX);
    localparam logic [5:0] C_MIN_MAX = 6'(MIN_MAX);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_minutes;
    logic [5:0] r_seconds;
    logic       r_wrap;
    logic [5:0] w_min_next;
    logic [5:0] w_sec_next;
    logic       w_wrap_next;
    logic       w_sec_last;
    logic       w_min_last;

    // ">=" keeps the counters bounded even if a field ever sat above its limit
    assign w_sec_last = (r_seconds >= C_SEC_MAX);
    assign w_min_last = (r_minutes >= C_MIN_MAX);

    // Next-state and next-time computation; ticks are judged against the current pause state
    always_comb begin
        w_state_next = r_state;
        w_min_next   = r_minutes;
        w_sec_next   = r_seconds;
        w_wrap_next  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (btnP) begin
                    w_state_next = ST_HOLD;
                end else begin
                    w_state_next = ST_RUN;
                end
                if (!swADJ) begin
                    if (tick_norm) begin
                        if (w_sec_last) begin
                            w_sec_next = 6'd0;
                            if (w_min_last) begin
                                w_min_next  = 6'd0;
                                w_wrap_next = 1'b1;
                            end else begin
                                w_min_next = r_minutes + 6'd1;
                            end
                        end else begin
                            w_sec_next = r_seconds + 6'd1;
                        end
                    end else begin
                        w_sec_next = r_seconds;
                    end
                end else begin
                    if (tick_adj) begin
                        if (swSEL) begin
                            w_sec_next = w_sec_last ? 6'd0 : r_seconds + 6'd1;
                        end else begin
                            w_min_next = w_min_last ? 6'd0 : r_minutes + 6'd1;
                        end
                    end else begin
                        w_min_next = r_minutes;
                    end
                end
            end
            ST_HOLD: begin
                if (btnP) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_HOLD;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // State and time registers; btnR overrides every other input
    always_ff @(posedge clk) begin
        if (btnR) begin
            r_state   <= ST_RUN;
            r_minutes <= 6'd0;
            r_seconds <= 6'd0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_minutes <= w_min_next;
            r_seconds <= w_sec_next;
            r_wrap    <= w_wrap_next;
        end
    end

    assign minutes = r_minutes;
    assign seconds = r_seconds;
    assign paused  = (r_state == ST_HOLD);
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_mmss_counter.sv
// Directed self-checking bench for mmss_counter, default limits and a 02:09 variant.
module tb_mmss_counter;

    logic       clk = 1'b0;
    logic       btnR = 1'b0;
    logic       tick_norm = 1'b0;
    logic       tick_adj = 1'b0;
    logic       btnP = 1'b0;
    logic       swADJ = 1'b0;
    logic       swSEL = 1'b0;
    logic [5:0] minutes, seconds, min2, sec2;
    logic       paused, wrap, paused2, wrap2;

    int n_checks = 0;
    int n_errors = 0;
    int wrap_cnt = 0;
    int wrap2_cnt = 0;
    int sec2_max = 0;
    int w0;

    mmss_counter dut (
        .clk(clk), .btnR(btnR), .tick_norm(tick_norm), .tick_adj(tick_adj),
        .btnP(btnP), .swADJ(swADJ), .swSEL(swSEL),
        .minutes(minutes), .seconds(seconds), .paused(paused), .wrap(wrap)
    );

    mmss_counter #(.SEC_MAX(9), .MIN_MAX(2)) dut_small (
        .clk(clk), .btnR(btnR), .tick_norm(tick_norm), .tick_adj(tick_adj),
        .btnP(btnP), .swADJ(swADJ), .swSEL(swSEL),
        .minutes(min2), .seconds(sec2), .paused(paused2), .wrap(wrap2)
    );

    always #5 clk = ~clk;

    // wrap-pulse counting and seconds ceiling for the small instance
    always @(negedge clk) begin
        if (wrap) wrap_cnt = wrap_cnt + 1;
        if (wrap2) wrap2_cnt = wrap2_cnt + 1;
        if (int'(sec2) > sec2_max) sec2_max = int'(sec2);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one-cycle pulse of the selected inputs; returns at the negedge after the sampling edge
    task automatic drive(input logic tn, input logic ta, input logic bp, input logic br);
        @(negedge clk);
        tick_norm = tn; tick_adj = ta; btnP = bp; btnR = br;
        @(negedge clk);
        tick_norm = 1'b0; tick_adj = 1'b0; btnP = 1'b0; btnR = 1'b0;
    endtask

    task automatic ticks(input int n, input logic adj);
        for (int i = 0; i < n; i++) drive(!adj, adj, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        swADJ = 1'b0; swSEL = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_min", minutes, 0);
        chk("rst_sec", seconds, 0);
        chk("rst_paused", paused, 0);
        chk("rst_wrap", wrap, 0);

        // 61 normal ticks -> 01:01, no wrap
        w0 = wrap_cnt;
        ticks(61, 1'b0);
        chk("t61_min", minutes, 1);
        chk("t61_sec", seconds, 1);
        chk("t61_paused", paused, 0);
        chk("t61_nowrap", wrap_cnt - w0, 0);

        // preload 59:58 via adjust, then roll over in normal mode
        do_reset();
        swADJ = 1'b1; swSEL = 1'b0;
        ticks(59, 1'b1);
        swSEL = 1'b1;
        ticks(58, 1'b1);
        chk("pre_min", minutes, 59);
        chk("pre_sec", seconds, 58);
        swADJ = 1'b0;
        w0 = wrap_cnt;
        ticks(1, 1'b0);
        chk("t5959_sec", seconds, 59);
        chk("t5959_wrap", wrap, 0);
        ticks(1, 1'b0);
        chk("roll_min", minutes, 0);
        chk("roll_sec", seconds, 0);
        chk("roll_wrap", wrap, 1);
        @(negedge clk);
        chk("roll_wrap_off", wrap, 0);
        chk("roll_wrap_once", wrap_cnt - w0, 1);

        // pause behaviour
        do_reset();
        ticks(5, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pause_on", paused, 1);
        ticks(10, 1'b0);
        chk("hold_sec", seconds, 5);
        chk("hold_paused", paused, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pause_off", paused, 0);
        ticks(1, 1'b0);
        chk("resume_sec", seconds, 6);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("same_cyc_sec", seconds, 7);
        chk("same_cyc_paused", paused, 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("unpause_tick_sec", seconds, 7);
        chk("unpause_tick_paused", paused, 0);

        // adjust minutes through a full cycle, seconds untouched
        do_reset();
        ticks(30, 1'b0);
        swADJ = 1'b1; swSEL = 1'b0;
        w0 = wrap_cnt;
        for (int i = 1; i <= 60; i++) begin
            ticks(1, 1'b1);
            chk("adj_min", minutes, i % 60);
            chk("adj_min_sec", seconds, 30);
        end
        swSEL = 1'b1;
        ticks(28, 1'b1);
        chk("adj_sec58", seconds, 58);
        ticks(1, 1'b1);
        chk("adj_sec59", seconds, 59);
        ticks(1, 1'b1);
        chk("adj_sec_wrap", seconds, 0);
        chk("adj_no_carry", minutes, 0);
        ticks(1, 1'b1);
        chk("adj_sec01", seconds, 1);
        ticks(3, 1'b0);
        chk("adj_ign_norm_sec", seconds, 1);
        chk("adj_ign_norm_min", minutes, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("adj_both_sec", seconds, 2);
        chk("adj_never_wrap", wrap_cnt - w0, 0);
        swADJ = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("norm_both_sec", seconds, 3);

        // reset dominates tick and pause at 12:34 paused
        do_reset();
        swADJ = 1'b1; swSEL = 1'b0;
        ticks(12, 1'b1);
        swSEL = 1'b1;
        ticks(34, 1'b1);
        swADJ = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_min", minutes, 12);
        chk("pre_rst_sec", seconds, 34);
        chk("pre_rst_paused", paused, 1);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        chk("dom_min", minutes, 0);
        chk("dom_sec", seconds, 0);
        chk("dom_paused", paused, 0);
        chk("dom_wrap", wrap, 0);

        // small limits: 30 ticks wrap 02:09 -> 00:00
        do_reset();
        w0 = wrap2_cnt;
        sec2_max = 0;
        ticks(29, 1'b0);
        chk("small_min29", min2, 2);
        chk("small_sec29", sec2, 9);
        ticks(1, 1'b0);
        chk("small_min", min2, 0);
        chk("small_sec", sec2, 0);
        chk("small_wrap", wrap2, 1);
        @(negedge clk);
        chk("small_wrap_once", wrap2_cnt - w0, 1);
        chk("small_sec_ceiling", sec2_max, 9);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
